mem_port_arbiter: RTL

Shares one single-port unified instruction/data memory between the fetch stage and the memory stage of the 5-stage pipeline. Requests use a req/gnt handshake and responses use rvalid, with at most one transaction outstanding. The data port has priority, bounded by a fetch anti-starvation counter. A fetch response can be discarded when a branch redirects the PC.

---
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and the data stage.
// Data has priority, fetch wins after MAX_D_STREAK data grants; one transaction in flight.
module mem_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [DATA_WIDTH-1:0] if_addr_i,
  input  logic                  if_kill_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [3:0]            d_be_i,
  input  logic [DATA_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, WAIT_IF, WAIT_D} state_t;

  localparam logic [3:0] MAX_STREAK = 4'(MAX_D_STREAK);

  state_t     state_q, state_d;
  logic [3:0] streak_q, streak_d;
  logic       lock_q, lock_d;
  logic       lock_data_q, lock_data_d;
  logic       kill_pend_q, kill_pend_d;

  logic resp, window, sel_data, sel_req, issue, grant;

  // The issue window opens on a response so a new request can overlap it.
  always_comb begin
    resp   = ~rst & mem_rvalid_i & (state_q != IDLE);
    window = ~rst & ((state_q == IDLE) | resp);
    if (lock_q) begin
      sel_data = lock_data_q;
    end else if (if_req_i & d_req_i) begin
      sel_data = (streak_q != MAX_STREAK);
    end else begin
      sel_data = d_req_i;
    end
    sel_req = sel_data ? d_req_i : if_req_i;
    issue   = window & sel_req;
    grant   = issue & mem_gnt_i;
  end

  assign mem_req_o   = issue;
  assign mem_we_o    = issue & sel_data & d_we_i;
  assign mem_be_o    = !issue ? 4'h0 : ((sel_data & d_we_i) ? d_be_i : 4'hF);
  assign mem_addr_o  = !issue ? '0 : (sel_data ? d_addr_i : if_addr_i);
  assign mem_wdata_o = (issue & sel_data) ? d_wdata_i : '0;

  assign if_gnt_o = grant & ~sel_data;
  assign d_gnt_o  = grant & sel_data;

  assign d_rvalid_o  = resp & (state_q == WAIT_D);
  assign if_rvalid_o = resp & (state_q == WAIT_IF) & ~kill_pend_q & ~if_kill_i;
  assign d_rdata_o   = d_rvalid_o ? mem_rdata_i : '0;
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    lock_d      = lock_q;
    lock_data_d = lock_data_q;
    kill_pend_d = kill_pend_q;

    if (grant) begin
      state_d = sel_data ? WAIT_D : WAIT_IF;
    end else if (resp) begin
      state_d = IDLE;
    end

    // A stalled request pins the selection until memory accepts it.
    if (issue & ~mem_gnt_i) begin
      lock_d      = 1'b1;
      lock_data_d = sel_data;
    end else if (grant) begin
      lock_d = 1'b0;
    end

    if (~if_req_i | if_gnt_o) begin
      streak_d = 4'd0;
    end else if (d_gnt_o && streak_q != MAX_STREAK) begin
      streak_d = streak_q + 4'd1;
    end

    if (resp & (state_q == WAIT_IF)) begin
      kill_pend_d = 1'b0;
    end else if ((state_q == WAIT_IF) & if_kill_i) begin
      kill_pend_d = 1'b1;
    end
    if (if_gnt_o & if_kill_i) begin
      kill_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      streak_q    <= 4'd0;
      lock_q      <= 1'b0;
      lock_data_q <= 1'b0;
      kill_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      lock_q      <= lock_d;
      lock_data_q <= lock_data_d;
      kill_pend_q <= kill_pend_d;
    end
  end

endmodule
